cache_line_lookup: RTL

//  Read side of the 4-line cache set: holds tag/data/valid for lines 0..3 and

---
 rtl/cache_line_lookup.sv | 103 ++++++++++
 1 files changed

// File: rtl/cache_line_lookup.sv
// cache_line_lookup: 4-line tag/data set with req/ack lookup; optional hit/miss counters under CACHE_LOOKUP_STATS_EN
module cache_line_lookup #(
  parameter int TAG_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [1:0]        wr_line,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_ready,
  output logic              rd_valid,
  input  logic              rd_ack,
  output logic              rd_hit,
  output logic [1:0]        rd_line,
  output logic [DATA_W-1:0] rd_data,
  output logic [3:0]        free_o,
  output logic [7:0]        hit_cnt,
  output logic [7:0]        miss_cnt
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  logic [1:0]        state;
  logic [3:0]        valid_q;
  logic [TAG_W-1:0]  tag_q [4];
  logic [DATA_W-1:0] data_q [4];
  logic [TAG_W-1:0]  req_tag;
  logic [3:0]        match;
  logic              hit;
  logic [1:0]        line;
  logic              resp_v;
  logic              take;
  assign rd_ready = state == IDLE;
  assign rd_valid = resp_v;
  assign free_o   = ~valid_q;
  assign take     = resp_v && rd_ack;
  // Compare the latched tag against every valid line; lowest matching index wins
  always_comb begin
    for (int i = 0; i < 4; i++) match[i] = valid_q[i] && tag_q[i] == req_tag;
    hit  = |match;
    line = match[0] ? 2'd0 : match[1] ? 2'd1 : match[2] ? 2'd2 : match[3] ? 2'd3 : 2'd0;
  end
  // Tag/data storage carries no reset; the valid bits alone qualify it
  always_ff @(posedge clk)
    if (wr_en) begin
      tag_q[wr_line]  <= wr_tag;
      data_q[wr_line] <= wr_data;
    end
  // Valid bits: cleared by reset, set by any write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid_q <= '0;
    else if (wr_en) valid_q[wr_line] <= 1'b1;
  // Handshake FSM; rd_valid rises one cycle into RESP and drops the cycle after rd_ack
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      resp_v  <= 1'b0;
      req_tag <= '0;
      rd_hit  <= 1'b0;
      rd_line <= 2'd0;
      rd_data <= '0;
    end else begin
      case (state)
        IDLE: if (rd_req) begin
          req_tag <= rd_tag;
          state   <= LOOKUP;
        end
        LOOKUP: begin
          rd_hit  <= hit;
          rd_line <= line;
          rd_data <= hit ? data_q[line] : '0;
          state   <= RESP;
        end
        RESP: begin
          resp_v <= !take;
          state  <= take ? IDLE : RESP;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef CACHE_LOOKUP_STATS_EN
  logic [7:0] hit_q;
  logic [7:0] miss_q;
  // Saturating outcome counters, stepped once per completed lookup
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hit_q  <= 8'h00;
      miss_q <= 8'h00;
    end else if (state == LOOKUP) begin
      if (hit && hit_q != 8'hFF) hit_q <= hit_q + 8'd1;
      if (!hit && miss_q != 8'hFF) miss_q <= miss_q + 8'd1;
    end
  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = 8'h00;
  assign miss_cnt = 8'h00;
`endif
endmodule
